// File: rtl/div_iter_unit.sv
// Iterative radix-2 restoring divider: one quotient bit per clock, signed/unsigned,
// with a cancel input and a valid/ready result handshake toward the ALU result mux.
module div_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_x,
  input  logic [WIDTH-1:0] div_y,
  input  logic             div_cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] div_q,
  output logic [WIDTH-1:0] div_r
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   abs_y;
  logic               sign_q, sign_r;

  logic [WIDTH-1:0]   abs_x_in, abs_y_in;
  logic [WIDTH+1:0]   rem_shift, trial;
  logic               last_step, y_zero;

  assign div_ready = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  assign y_zero    = (div_y == '0);
  assign abs_x_in  = (div_signed && div_x[WIDTH-1]) ? -div_x : div_x;
  assign abs_y_in  = (div_signed && div_y[WIDTH-1]) ? -div_y : div_y;
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  // Trial subtraction carries one extra bit so its sign shows whether |y| fits.
  assign rem_shift = {rem, quo[WIDTH-1]};
  assign trial     = rem_shift - {2'b00, abs_y};

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assigned first so no path through the case leaves state_d
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    if (div_cancel) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (div_valid) state_d = y_zero ? FIX : CALC;
        CALC:    if (last_step) state_d = FIX;
        FIX:     state_d = DONE;
        DONE:    if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      abs_y  <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      div_q  <= '0;
      div_r  <= '0;
    end else if (div_cancel) begin
      cnt <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (div_valid) begin
            cnt <= '0;
            if (y_zero) begin
              // Divide by zero: FIX passes these through untouched.
              quo    <= '1;
              rem    <= {1'b0, div_x};
              sign_q <= 1'b0;
              sign_r <= 1'b0;
            end else begin
              quo    <= abs_x_in;
              rem    <= '0;
              abs_y  <= abs_y_in;
              sign_q <= div_signed & (div_x[WIDTH-1] ^ div_y[WIDTH-1]);
              sign_r <= div_signed & div_x[WIDTH-1];
            end
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (!trial[WIDTH+1]) begin
            rem <= trial[WIDTH:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_shift[WIDTH:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          div_q <= sign_q ? -quo : quo;
          div_r <= sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule
